// File: rtl/mcpu_alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter:
// FSM encoding, ALU opcodes and requester ids.
package mcpu_alu_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU: AND/OR/XOR/ADD, overflow is the
// unsigned carry-out of ADD.
module mcpu_alu
    import mcpu_alu_arbiter_pkg::*;
#(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 8
) (
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    output logic [WORD_SIZE-1:0] out,
    output logic                 overflow
);

    logic [WORD_SIZE:0] sum;

    assign sum = {1'b0, r1} + {1'b0, r2};

    always_comb begin
        out      = '0;
        overflow = 1'b0;
        case (opcode)
            CMD_SIZE'(OP_AND): out = r1 & r2;
            CMD_SIZE'(OP_OR):  out = r1 | r2;
            CMD_SIZE'(OP_XOR): out = r1 ^ r2;
            CMD_SIZE'(OP_ADD): begin
                out      = sum[WORD_SIZE-1:0];
                overflow = sum[WORD_SIZE];
            end
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/mcpu_rr_arb2.sv
// Two-way round-robin grant; on contention the requester
// that was not granted last wins.
module mcpu_rr_arb2
    import mcpu_alu_arbiter_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = a_valid | b_valid;
    assign gnt_id    = b_valid & (~a_valid | (last == ID_A));

endmodule

// File: rtl/mcpu_alu_arbiter.sv
// Shares one ALU between requesters A and B with a
// round-robin IDLE/EXEC/RESP handshake FSM.
module mcpu_alu_arbiter
    import mcpu_alu_arbiter_pkg::*;
#(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [CMD_SIZE-1:0]  a_opcode,
    input  logic [WORD_SIZE-1:0] a_r1,
    input  logic [WORD_SIZE-1:0] a_r2,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [CMD_SIZE-1:0]  b_opcode,
    input  logic [WORD_SIZE-1:0] b_r1,
    input  logic [WORD_SIZE-1:0] b_r2,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [WORD_SIZE-1:0] rsp_out,
    output logic                 rsp_overflow,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [7:0]           done_a,
    output logic [7:0]           done_b
);

    state_t               state;
    logic                 last;
    logic                 op_id;
    logic [CMD_SIZE-1:0]  op_cmd;
    logic [WORD_SIZE-1:0] op_r1;
    logic [WORD_SIZE-1:0] op_r2;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 alu_ovf;
    logic                 gnt_valid;
    logic                 gnt_id;
    logic                 grant;

    mcpu_rr_arb2 u_arb (
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    mcpu_alu #(
        .CMD_SIZE  (CMD_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .opcode   (op_cmd),
        .r1       (op_r1),
        .r2       (op_r2),
        .out      (alu_out),
        .overflow (alu_ovf)
    );

    // Ready is forced low while reset is asserted, even though state is IDLE.
    assign grant   = rst_n & (state == ST_IDLE) & gnt_valid;
    assign a_ready = grant & (gnt_id == ID_A);
    assign b_ready = grant & (gnt_id == ID_B);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last         <= ID_B;
            op_id        <= ID_A;
            op_cmd       <= '0;
            op_r1        <= '0;
            op_r2        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= ID_A;
            rsp_out      <= '0;
            rsp_overflow <= 1'b0;
            busy         <= 1'b0;
            done_a       <= '0;
            done_b       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        op_id  <= gnt_id;
                        op_cmd <= gnt_id ? b_opcode : a_opcode;
                        op_r1  <= gnt_id ? b_r1 : a_r1;
                        op_r2  <= gnt_id ? b_r2 : a_r2;
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out      <= alu_out;
                    rsp_overflow <= alu_ovf;
                    rsp_id       <= op_id;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (rsp_id == ID_B) done_b <= done_b + 8'd1;
                        else                done_a <= done_a + 8'd1;
                        last      <= rsp_id;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
